lap_timer: RTL and testbench
============================

LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 Parameter PRESC_DIV, default 73729; clk cycles per hundredth-second tick; legal range 2..2^20.
REQ-002 Parameter SCAN_DIV, default 7374; clk cycles per display field slot; legal range 1..2^16.
REQ-003 Parameter DAY_MAX, default 99; last day value before the day field wraps to 0; legal range 1..127.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  synchronous level; sampled each clk; starts or resumes counting.
REQ-007 stop  input  1  synchronous level; pauses counting.
REQ-008 clear  input  1  synchronous level; zeroes time, returns to IDLE.
REQ-009 lap  input  1  synchronous; rising edge (detected internally) toggles lap hold.
REQ-010 out  output  7  value of the currently displayed field.
REQ-011 sel  output  3  displayed field index: 0=hs, 1=sec, 2=min, 3=hr, 4=dy.
REQ-012 running  output  1  high while the FSM is in RUN.
REQ-013 lap_valid  output  1  high while a lap snapshot is displayed.

Function
REQ-014 FSM states IDLE, RUN and PAUSE; per-cycle priority clear > stop > start.
- IDLE: start->RUN.
- RUN: stop->PAUSE; clear->IDLE.
- PAUSE: start->RUN; clear->IDLE.
REQ-015 Prescaler counts 0..PRESC_DIV-1 only in RUN, holds its value in PAUSE, and is zeroed in IDLE; tick is asserted for one cycle when it wraps from PRESC_DIV-1 to 0.
REQ-016 On tick, the counters cascade in the same cycle:
- hs: 0..99
- sec: 0..59
- min: 0..59
- hr: 0..23
- dy: 0..DAY_MAX, then wraps to 0
- Each field increments only when all lower fields wrap.
REQ-017 Field registers are 7 bits; no field ever holds a value above its maximum.
REQ-018 The tick-to-counter update latency is 1 clk; a tick and a clear in the same cycle resolve to clear, with all fields 0 next cycle.
REQ-019 A stop in the cycle a tick would occur suppresses that tick; the prescaler holds PRESC_DIV-1.
REQ-020 Scanner divider counts 0..SCAN_DIV-1 continuously in every state.
- On wrap, sel advances 0,1,2,3,4,0,... (wraps after 4).
- out = the selected field, registered; out changes 1 clk after sel.
REQ-021 Entering RUN from IDLE resets the scanner divider and sel to 0.
REQ-022 running is registered and equals (state==RUN).

Reset
REQ-023 While reset is high, the block asynchronously forces:
- state=IDLE
- prescaler=0, scanner divider=0
- all fields=0, sel=0, out=0
- running=0, lap_valid=0
- lap snapshot registers=0, lap edge detector=0
REQ-024 After reset is released, the first active clk edge is processed normally; reset asserted mid-count discards all time.

Configuration
REQ-025 Macro LAP_TIMER_LAP_EN selects the lap feature.
- Defined: a lap rising edge in RUN or PAUSE with lap_valid=0 copies all five fields into snapshot registers and sets lap_valid=1. While lap_valid=1, out shows snapshot fields and live counting continues. The next lap rising edge clears lap_valid. clear also clears lap_valid. A lap edge in IDLE is ignored.
- Undefined: no snapshot registers; the lap input is ignored; lap_valid is tied 0; out always shows live fields.

Verification
REQ-026 PRESC_DIV=4, start for 1 cycle -> hs=1 after 4 clk and hs=2 after 8 clk; running=1.
REQ-027 Preload via run to 99.59.59.23.DAY_MAX with PRESC_DIV=2, then 1 tick -> all fields 0 (day wrap).
REQ-028 RUN with prescaler=2, stop -> PAUSE, prescaler holds at 2 for 100 clk; start -> next tick arrives after PRESC_DIV-2 clk.
REQ-029 clear, start and tick asserted in the same cycle -> IDLE, all fields 0, running=0.
REQ-030 SCAN_DIV=3 -> sel sequence 0,1,2,3,4,0 with one step every 3 clk; out matches each field 1 clk later.
REQ-031 With LAP_TIMER_LAP_EN defined: lap at hs=37 -> out for sel=0 stays 37 while live hs advances; second lap -> live value shown and lap_valid=0. With the macro undefined: lap_valid stays 0.

Source files
------------

// File: rtl/lap_timer.sv
// lap_timer: stopwatch counting hundredths/seconds/minutes/hours/days with a scanned field display.
// Build option: define LAP_TIMER_LAP_EN to add the lap snapshot/hold feature.
// Ports: clk; reset (async, active-high); start/stop/clear (levels, priority clear > stop > start);
//        lap (rising edge toggles lap hold); out (displayed field value); sel (0=hs,1=sec,2=min,3=hr,4=dy);
//        running (state is RUN); lap_valid (lap snapshot on display).
module lap_timer #(
    parameter int PRESC_DIV = 73729,
    parameter int SCAN_DIV  = 7374,
    parameter int DAY_MAX   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [6:0] out,
    output logic [2:0] sel,
    output logic       running,
    output logic       lap_valid
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t state, state_nx;
    logic [19:0] presc;
    logic [15:0] scan;
    logic [6:0] hs, sec, mins, hr, dy;
    logic [6:0] live_fld, disp_fld;
    logic cnt_en, tick, hs_w, sec_w, min_w, hr_w, dy_w, scan_w, enter_run;

    // stop only has an effect from RUN; in IDLE it still outranks start
    always_comb state_nx = clear ? IDLE : stop ? (state == RUN ? PAUSE : state) : start ? RUN : state;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    // counting is gated by stop/clear in the same cycle so a coincident tick is dropped
    assign cnt_en    = (state == RUN) && !stop && !clear;
    assign tick      = cnt_en && (presc == 20'(PRESC_DIV - 1));
    assign enter_run = (state == IDLE) && (state_nx == RUN);
    assign hs_w      = hs == 7'd99;
    assign sec_w     = sec == 7'd59;
    assign min_w     = mins == 7'd59;
    assign hr_w      = hr == 7'd23;
    assign dy_w      = dy == 7'(DAY_MAX);
    assign scan_w    = scan == 16'(SCAN_DIV - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) presc <= '0;
        else if (state == IDLE || clear) presc <= '0;
        else if (cnt_en) presc <= tick ? '0 : presc + 20'd1;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            {hs, sec, mins, hr, dy} <= '0;
        end else if (clear) begin
            {hs, sec, mins, hr, dy} <= '0;
        end else if (tick) begin
            hs <= hs_w ? '0 : hs + 7'd1;
            if (hs_w) sec <= sec_w ? '0 : sec + 7'd1;
            if (hs_w && sec_w) mins <= min_w ? '0 : mins + 7'd1;
            if (hs_w && sec_w && min_w) hr <= hr_w ? '0 : hr + 7'd1;
            if (hs_w && sec_w && min_w && hr_w) dy <= dy_w ? '0 : dy + 7'd1;
        end

    // display scanner free-runs in every state; realigned to hs when a fresh run starts
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            scan <= '0;
            sel  <= '0;
        end else if (enter_run) begin
            scan <= '0;
            sel  <= '0;
        end else begin
            scan <= scan_w ? '0 : scan + 16'd1;
            if (scan_w) sel <= (sel == 3'd4) ? 3'd0 : sel + 3'd1;
        end

    always_comb live_fld = (sel == 3'd0) ? hs : (sel == 3'd1) ? sec : (sel == 3'd2) ? mins : (sel == 3'd3) ? hr : dy;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            out     <= '0;
            running <= 1'b0;
        end else begin
            out     <= disp_fld;
            running <= state_nx == RUN;
        end

`ifdef LAP_TIMER_LAP_EN
    logic lap_q, lap_rise;
    logic [6:0] s_hs, s_sec, s_min, s_hr, s_dy, snap_fld;

    assign lap_rise = lap && !lap_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            lap_q     <= 1'b0;
            lap_valid <= 1'b0;
            {s_hs, s_sec, s_min, s_hr, s_dy} <= '0;
        end else begin
            lap_q <= lap;
            if (clear) lap_valid <= 1'b0;
            else if (lap_rise && state != IDLE) begin
                lap_valid <= !lap_valid;
                if (!lap_valid) {s_hs, s_sec, s_min, s_hr, s_dy} <= {hs, sec, mins, hr, dy};
            end
        end

    always_comb snap_fld = (sel == 3'd0) ? s_hs : (sel == 3'd1) ? s_sec : (sel == 3'd2) ? s_min : (sel == 3'd3) ? s_hr : s_dy;
    assign disp_fld = lap_valid ? snap_fld : live_fld;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_valid  = 1'b0;
    assign disp_fld   = live_fld;
`endif
endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed scoreboard bench for lap_timer (small prescaler/scanner/day range)
module tb_lap_timer;
    localparam int PD = 4;
    localparam int SD = 3;
    localparam int DM = 3;
`ifdef LAP_TIMER_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, start, stop, clear, lap;
    logic [6:0] out;
    logic [2:0] sel;
    logic running, lap_valid;
    int vecs = 0;
    int errs = 0;
    int sb[$];
    int fld[5];

    lap_timer #(.PRESC_DIV(PD), .SCAN_DIV(SD), .DAY_MAX(DM)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .out(out), .sel(sel), .running(running), .lap_valid(lap_valid)
    );

    always #5 clk = ~clk;

    task automatic ex(input int v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input int obs);
        int e;
        vecs++;
        e = (sb.size() == 0) ? -1 : sb.pop_front();
        assert (obs === e) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // lands on the first negedge after sel changes to k
    task automatic sync_sel(input logic [2:0] k);
        int n = 0;
        ex(int'(k));
        while (sel == k && n < 20) begin @(negedge clk); n++; end
        while (sel != k && n < 20) begin @(negedge clk); n++; end
        chk("sel_sync", int'(sel));
    endtask

    task automatic preload(input logic [6:0] a, b, c, d, e);
        force dut.hs = a;
        force dut.sec = b;
        force dut.mins = c;
        force dut.hr = d;
        force dut.dy = e;
        #1;
        release dut.hs;
        release dut.sec;
        release dut.mins;
        release dut.hr;
        release dut.dy;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        step(2);
        ex(0); chk("rst_running", int'(running));
        ex(0); chk("rst_out", int'(out));
        ex(0); chk("rst_sel", int'(sel));
        ex(0); chk("rst_lap_valid", int'(lap_valid));
        ex(0); chk("rst_presc", int'(dut.presc));
        reset = 1'b0;
        step(2);
        start = 1'b1; ex(1); ex(0); ex(0);
        step(1); start = 1'b0;
        chk("start_running", int'(running));
        chk("start_sel0", int'(sel));
        chk("start_hs0", int'(dut.hs));
        ex(0); ex(0); step(2);
        chk("scan_hold_sel", int'(sel)); chk("hs_before_tick", int'(dut.hs));
        ex(1); ex(0); step(1);
        chk("scan_step_sel", int'(sel)); chk("hs_3clk", int'(dut.hs));
        ex(1); step(1); chk("hs_4clk", int'(dut.hs));
        ex(2); step(4); chk("hs_8clk", int'(dut.hs));
        ex(2); step(2); chk("presc_at2", int'(dut.presc));
        stop = 1'b1; ex(0); ex(2);
        step(1); stop = 1'b0;
        chk("pause_running", int'(running)); chk("pause_presc", int'(dut.presc));
        ex(2); ex(2); step(100);
        chk("pause_hold_presc", int'(dut.presc)); chk("pause_hold_hs", int'(dut.hs));
        start = 1'b1; ex(1); ex(2);
        step(1); start = 1'b0;
        chk("resume_running", int'(running)); chk("resume_presc", int'(dut.presc));
        ex(2); step(1); chk("resume_hs_1clk", int'(dut.hs));
        ex(3); step(1); chk("resume_hs_2clk", int'(dut.hs));
        step(3); stop = 1'b1; ex(PD - 1); ex(3); ex(0);
        step(1); stop = 1'b0;
        chk("stop_tick_presc", int'(dut.presc)); chk("stop_tick_hs", int'(dut.hs));
        chk("stop_tick_running", int'(running));
        fld = '{3, 11, 22, 5, 2};
        preload(7'd3, 7'd11, 7'd22, 7'd5, 7'd2);
        sync_sel(3'd0);
        for (int k = 0; k < 5; k++) begin
            ex(fld[k]); ex(k); step(1);
            chk("scan_out", int'(out)); chk("scan_sel_a", int'(sel));
            ex(k); step(1); chk("scan_sel_b", int'(sel));
            ex((k + 1) % 5); step(1); chk("scan_sel_next", int'(sel));
        end
        preload(7'd37, 7'd11, 7'd22, 7'd5, 7'd2);
        lap = 1'b1; ex(int'(LAP));
        step(1); lap = 1'b0;
        chk("lap_set_valid", int'(lap_valid));
        start = 1'b1; step(1); start = 1'b0;
        ex(38); step(1); chk("lap_live_hs38", int'(dut.hs));
        ex(39); ex(int'(LAP)); step(4);
        chk("lap_live_hs39", int'(dut.hs)); chk("lap_valid_held", int'(lap_valid));
        stop = 1'b1; step(1); stop = 1'b0;
        sync_sel(3'd0);
        ex(LAP ? 37 : 39); step(1); chk("lap_out_hs", int'(out));
        sync_sel(3'd1);
        ex(11); step(1); chk("lap_out_sec", int'(out));
        lap = 1'b1; ex(0);
        step(1); lap = 1'b0;
        chk("lap_clear_valid", int'(lap_valid));
        sync_sel(3'd0);
        ex(39); step(1); chk("lap_release_out", int'(out));
        start = 1'b1; step(1); start = 1'b0;
        lap = 1'b1; ex(39); ex(int'(LAP));
        step(3); lap = 1'b0;
        chk("pre_clear_hs", int'(dut.hs)); chk("pre_clear_lap_valid", int'(lap_valid));
        clear = 1'b1; start = 1'b1;
        ex(0); ex(0); ex(0); ex(0); ex(0); ex(0);
        step(1); clear = 1'b0; start = 1'b0;
        chk("clr_running", int'(running)); chk("clr_hs", int'(dut.hs));
        chk("clr_sec", int'(dut.sec)); chk("clr_dy", int'(dut.dy));
        chk("clr_presc", int'(dut.presc)); chk("clr_lap_valid", int'(lap_valid));
        ex(0); ex(0); step(5);
        chk("idle_hs", int'(dut.hs)); chk("idle_presc", int'(dut.presc));
        start = 1'b1; step(1); start = 1'b0;
        preload(7'd99, 7'd59, 7'd59, 7'd22, 7'd1);
        ex(99); ex(22); step(3);
        chk("preload_hs", int'(dut.hs)); chk("preload_hr", int'(dut.hr));
        ex(0); ex(0); ex(0); ex(23); ex(1); step(1);
        chk("hr_cas_hs", int'(dut.hs)); chk("hr_cas_sec", int'(dut.sec));
        chk("hr_cas_min", int'(dut.mins)); chk("hr_cas_hr", int'(dut.hr)); chk("hr_cas_dy", int'(dut.dy));
        preload(7'd99, 7'd59, 7'd59, 7'd23, 7'(DM));
        ex(DM); step(3); chk("day_max_dy", int'(dut.dy));
        ex(0); ex(0); ex(0); ex(0); ex(0); step(1);
        chk("wrap_hs", int'(dut.hs)); chk("wrap_sec", int'(dut.sec));
        chk("wrap_min", int'(dut.mins)); chk("wrap_hr", int'(dut.hr)); chk("wrap_dy", int'(dut.dy));
        preload(7'd99, 7'd10, 7'd7, 7'd4, 7'd0);
        ex(0); ex(11); ex(7); ex(4); step(4);
        chk("sec_cas_hs", int'(dut.hs)); chk("sec_cas_sec", int'(dut.sec));
        chk("sec_cas_min", int'(dut.mins)); chk("sec_cas_hr", int'(dut.hr));
        ex(1); step(4); chk("mid_hs", int'(dut.hs));
        #2 reset = 1'b1;
        ex(0); ex(0); ex(0); ex(0); ex(0);
        #1;
        chk("async_rst_running", int'(running)); chk("async_rst_hs", int'(dut.hs));
        chk("async_rst_sec", int'(dut.sec)); chk("async_rst_presc", int'(dut.presc));
        chk("async_rst_sel", int'(sel));
        reset = 1'b0; start = 1'b1;
        ex(1); ex(0);
        step(1); start = 1'b0;
        chk("post_rst_running", int'(running)); chk("post_rst_hs", int'(dut.hs));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
